// File: rtl/basics_resp_gen.sv
// basics_resp_gen: builds a response frame (ADDR, EID, LEN, payload) for
// NAK, version and, optionally, query requests, and holds finished responses
// in a byte buffer that a granted reader drains one byte per latch strobe.
// Optional build macro: BASICS_QUERY_EN enables query-address handling.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for generate_nak or a version/query frame
// S_GET_EID  | capturing the first data byte (EID)
// S_SKIP_LEN | discarding the inbound length byte
// S_GET_VER  | shifting in VERSION_BYTES of peer version
// S_EMIT     | writing the response into the buffer, one byte per cycle
// S_WAIT_END | response done or dropped; wait for the frame to close
module basics_resp_gen #(
  parameter int                           VERSION_BYTES = 2,
  parameter logic [8*VERSION_BYTES-1:0]   VERSION       = 16'h0000,
  parameter logic [7:0]                   QUERY_ADDR    = 8'h3F,
  parameter logic [7:0]                   VER_ADDR      = 8'h56,
  parameter logic [7:0]                   DEV_ID        = 8'h00,
  parameter int                           BUF_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       generate_nak,
  input  logic [7:0] ma_data,
  input  logic [7:0] ma_addr,
  input  logic       ma_data_valid,
  input  logic       ma_frame_valid,
  inout  wire  [7:0] sl_data,
  inout  wire        sl_overflow,
  output logic       sl_arb_request,
  input  logic       sl_arb_grant,
  input  logic       sl_data_latch,
  output logic [7:0] drop_count
);

  localparam int VB = VERSION_BYTES;
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_EID, S_SKIP_LEN, S_GET_VER, S_EMIT, S_WAIT_END
  } state_t;

  typedef enum logic [1:0] {CMD_NAK, CMD_VER, CMD_QRY} cmd_t;

  state_t          r_state;
  cmd_t            r_cmd;
  logic [7:0]      r_addr;
  logic [7:0]      r_eid;
  logic [8*VB-1:0] r_ver;
  logic [2:0]      r_ver_cnt;
  logic [3:0]      r_idx;
  logic [7:0]      r_drop;
  logic [8:0]      r_mem [BUF_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_frames;

  logic            w_ver_match;
  logic            w_long;
  logic [3:0]      w_resp_len;
  logic            w_last;
  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_free;
  logic            w_no_room;
  logic [7:0]      w_byte;
  logic [8*VB-1:0] w_ver_shift;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [8:0]      w_head;

`ifndef BASICS_QUERY_EN
  logic [15:0] w_unused_qry;
  assign w_unused_qry = {QUERY_ADDR, DEV_ID};
`endif

  // Response geometry and buffer occupancy.
  assign w_ver_match = (r_ver == VERSION);
  assign w_long      = (r_cmd == CMD_VER) && !w_ver_match;
  assign w_resp_len  = w_long ? 4'(VB + 4) : 4'd4;
  assign w_last      = (r_idx == w_resp_len - 4'd1);
  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_free      = PW'(BUF_DEPTH) - w_used;
  assign w_no_room   = (w_free < PW'(w_resp_len));
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push      = (r_state == S_EMIT) && !((r_idx == 4'd0) && w_no_room);
  assign w_pop       = sl_data_latch && sl_arb_grant && !w_empty;

  // Reader side: drive the bus only while granted.
  assign sl_data        = sl_arb_grant ? w_head[7:0] : 8'bz;
  assign sl_overflow    = sl_arb_grant ? 1'b0 : 1'bz;
  assign sl_arb_request = (r_frames != '0);
  assign drop_count     = r_drop;

  // Next version shift value: older bytes move toward the MSB.
  always_comb begin
    w_ver_shift      = r_ver << 8;
    w_ver_shift[7:0] = ma_data;
  end

  // Select the response byte for the current emit index.
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0: w_byte = r_addr;
      4'd1: w_byte = r_eid;
      4'd2: w_byte = w_long ? 8'(VB + 1) : 8'd1;
      4'd3: begin
        case (r_cmd)
          CMD_NAK: w_byte = 8'h01;
          CMD_VER: w_byte = w_ver_match ? 8'h00 : 8'h01;
`ifdef BASICS_QUERY_EN
          CMD_QRY: w_byte = DEV_ID;
`endif
          default: w_byte = 8'h00;
        endcase
      end
      default: begin
        for (int k = 0; k < VB; k++) begin
          if (r_idx == 4'(4 + k)) w_byte = VERSION[8*(VB-1-k) +: 8];
        end
      end
    endcase
  end

  // Request decode, inbound capture and response emission.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cmd     <= CMD_NAK;
      r_addr    <= 8'h00;
      r_eid     <= 8'h00;
      r_ver     <= '0;
      r_ver_cnt <= 3'd0;
      r_idx     <= 4'd0;
      r_drop    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= 4'd0;
          if (generate_nak) begin
            r_cmd   <= CMD_NAK;
            r_addr  <= ma_addr;
            r_state <= S_GET_EID;
          end else if (ma_frame_valid && ma_addr == VER_ADDR) begin
            r_cmd   <= CMD_VER;
            r_addr  <= ma_addr;
            r_state <= S_GET_EID;
          end
`ifdef BASICS_QUERY_EN
          else if (ma_frame_valid && ma_addr == QUERY_ADDR) begin
            r_cmd   <= CMD_QRY;
            r_addr  <= ma_addr;
            r_state <= S_GET_EID;
          end
`endif
        end
        S_GET_EID: begin
          if (!ma_frame_valid) r_state <= S_IDLE;
          else if (ma_data_valid) begin
            r_eid   <= ma_data;
            r_state <= S_SKIP_LEN;
          end
        end
        S_SKIP_LEN: begin
          if (!ma_frame_valid) r_state <= S_IDLE;
          else if (ma_data_valid) begin
            r_ver_cnt <= 3'd0;
            r_state   <= (r_cmd == CMD_VER) ? S_GET_VER : S_EMIT;
          end
        end
        S_GET_VER: begin
          if (!ma_frame_valid) r_state <= S_IDLE;
          else if (ma_data_valid) begin
            r_ver     <= w_ver_shift;
            r_ver_cnt <= r_ver_cnt + 3'd1;
            if (r_ver_cnt == 3'(VB - 1)) r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (r_idx == 4'd0 && w_no_room) begin
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            r_state <= S_WAIT_END;
          end else begin
            r_idx <= r_idx + 4'd1;
            if (w_last) r_state <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (!ma_frame_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage: data byte plus end-of-frame tag.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_last, w_byte};
  end

  // Pointers and complete-frame count; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_frames <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_frames <= r_frames + PW'(w_push && w_last) - PW'(w_pop && w_head[8]);
    end
  end

endmodule

// File: tb/tb_basics_resp_gen.sv
// Directed bench for basics_resp_gen: default-parameter instance plus a
// BUF_DEPTH=8 instance used for the drop-count scenario.
module tb_basics_resp_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       generate_nak;
  logic [7:0] ma_data;
  logic [7:0] ma_addr;
  logic       ma_data_valid;
  logic       ma_frame_valid;
  wire  [7:0] sl_data;
  wire        sl_overflow;
  logic       sl_arb_request;
  logic       sl_arb_grant;
  logic       sl_data_latch;
  logic [7:0] drop_count;

  logic       en8;
  wire  [7:0] unused_sl_data8;
  wire        unused_sl_overflow8;
  logic       req8;
  logic [7:0] drop8;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  basics_resp_gen u_dut (
    .clk            (clk),
    .rst            (rst),
    .generate_nak   (generate_nak),
    .ma_data        (ma_data),
    .ma_addr        (ma_addr),
    .ma_data_valid  (ma_data_valid),
    .ma_frame_valid (ma_frame_valid),
    .sl_data        (sl_data),
    .sl_overflow    (sl_overflow),
    .sl_arb_request (sl_arb_request),
    .sl_arb_grant   (sl_arb_grant),
    .sl_data_latch  (sl_data_latch),
    .drop_count     (drop_count)
  );

  basics_resp_gen #(.BUF_DEPTH(8)) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .generate_nak   (generate_nak & en8),
    .ma_data        (ma_data),
    .ma_addr        (ma_addr),
    .ma_data_valid  (ma_data_valid & en8),
    .ma_frame_valid (ma_frame_valid & en8),
    .sl_data        (unused_sl_data8),
    .sl_overflow    (unused_sl_overflow8),
    .sl_arb_request (req8),
    .sl_arb_grant   (1'b0),
    .sl_data_latch  (1'b0),
    .drop_count     (drop8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives one inbound frame from tx_q.
  task send_frame(input logic [7:0] addr, input logic nak);
    ma_frame_valid = 1'b1;
    ma_addr        = addr;
    generate_nak   = nak;
    foreach (tx_q[i]) begin
      @(negedge clk);
      generate_nak  = 1'b0;
      ma_data_valid = 1'b1;
      ma_data       = tx_q[i];
    end
    @(negedge clk);
    ma_data_valid = 1'b0;
    generate_nak  = 1'b0;
    repeat (8) @(negedge clk);
    ma_frame_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Called at a falling edge; drains exp_q.size() bytes, one pop per cycle.
  task read_frame(input string tag);
    sl_arb_grant  = 1'b1;
    sl_data_latch = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      check($sformatf("%s_byte%0d", tag, i), sl_data, exp_q[i]);
      if (i == 0) check($sformatf("%s_ovf", tag), {7'd0, sl_overflow}, 8'h00);
      if (i == exp_q.size() - 1) check($sformatf("%s_req_before_last", tag), {7'd0, sl_arb_request}, 8'h01);
      @(negedge clk);
    end
    sl_data_latch = 1'b0;
    sl_arb_grant  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; generate_nak = 1'b0; ma_data = 8'h00; ma_addr = 8'h00;
    ma_data_valid = 1'b0; ma_frame_valid = 1'b0; sl_arb_grant = 1'b0;
    sl_data_latch = 1'b0; en8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_req", {7'd0, sl_arb_request}, 8'h00);
    check("rst_drop", drop_count, 8'h00);
    check("rst_req8", {7'd0, req8}, 8'h00);

    // Latch strobes on an empty buffer are ignored
    sl_arb_grant = 1'b1; sl_data_latch = 1'b1;
    repeat (3) @(negedge clk);
    check("empty_ovf", {7'd0, sl_overflow}, 8'h00);
    sl_arb_grant = 1'b0; sl_data_latch = 1'b0;
    check("empty_req", {7'd0, sl_arb_request}, 8'h00);

    // Version match
    tx_q = '{8'h12, 8'h04, 8'h00, 8'h00};
    send_frame(8'h56, 1'b0);
    check("match_req", {7'd0, sl_arb_request}, 8'h01);
    exp_q = '{8'h56, 8'h12, 8'h01, 8'h00};
    read_frame("match");
    #1 check("match_req_after", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    // Version mismatch
    tx_q = '{8'h12, 8'h04, 8'h01, 8'h02};
    send_frame(8'h56, 1'b0);
    exp_q = '{8'h56, 8'h12, 8'h03, 8'h01, 8'h00, 8'h00};
    read_frame("mismatch");
    #1 check("mismatch_req_after", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    // NAK wins over version address
    tx_q = '{8'h34, 8'h02, 8'hAA, 8'hBB};
    send_frame(8'h56, 1'b1);
    exp_q = '{8'h56, 8'h34, 8'h01, 8'h01};
    read_frame("nak");
    @(negedge clk);

    // Abort after EID: nothing written
    ma_frame_valid = 1'b1; ma_addr = 8'h56;
    @(negedge clk);
    ma_data_valid = 1'b1; ma_data = 8'h12;
    @(negedge clk);
    ma_data_valid = 1'b0; ma_frame_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_req", {7'd0, sl_arb_request}, 8'h00);
    check("abort_drop", drop_count, 8'h00);
    tx_q = '{8'h77, 8'h04, 8'h00, 8'h00};
    send_frame(8'h56, 1'b0);
    exp_q = '{8'h56, 8'h77, 8'h01, 8'h00};
    read_frame("post_abort");
    #1 check("post_abort_req", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    // Query frame
    tx_q = '{8'h21, 8'h02};
    send_frame(8'h3F, 1'b0);
`ifdef BASICS_QUERY_EN
    check("query_req", {7'd0, sl_arb_request}, 8'h01);
    exp_q = '{8'h3F, 8'h21, 8'h01, 8'h00};
    read_frame("query");
    @(negedge clk);
`else
    check("query_ignored_req", {7'd0, sl_arb_request}, 8'h00);
`endif

    // Three mismatch responses without grant; depth 8 keeps one, depth 16 two
    en8 = 1'b1;
    tx_q = '{8'hA1, 8'h04, 8'h01, 8'h02};
    send_frame(8'h56, 1'b0);
    tx_q = '{8'hA2, 8'h04, 8'h01, 8'h02};
    send_frame(8'h56, 1'b0);
    tx_q = '{8'hA3, 8'h04, 8'h01, 8'h02};
    send_frame(8'h56, 1'b0);
    en8 = 1'b0;
    check("d8_drop", drop8, 8'h02);
    check("d8_req", {7'd0, req8}, 8'h01);
    check("d16_drop", drop_count, 8'h01);
    // Exactly four bytes left: a match response fills the buffer
    tx_q = '{8'hA4, 8'h04, 8'h00, 8'h00};
    send_frame(8'h56, 1'b0);
    check("full_drop", drop_count, 8'h01);
    exp_q = '{8'h56, 8'hA1, 8'h03, 8'h01, 8'h00, 8'h00};
    read_frame("full_f1");
    exp_q = '{8'h56, 8'hA2, 8'h03, 8'h01, 8'h00, 8'h00};
    read_frame("full_f2");
    exp_q = '{8'h56, 8'hA4, 8'h01, 8'h00};
    read_frame("full_f3");
    #1 check("full_req_after", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    // Read one frame while the next is written, ending in the same cycle
    tx_q = '{8'hB1, 8'h04, 8'h01, 8'h02};
    send_frame(8'h56, 1'b0);
    tx_q = '{8'hB2, 8'h04, 8'h01, 8'h02};
    exp_q = '{8'h56, 8'hB1, 8'h03, 8'h01, 8'h00, 8'h00};
    fork
      send_frame(8'h56, 1'b0);
      begin
        repeat (5) @(negedge clk);
        read_frame("overlap_f1");
      end
    join
    check("overlap_req_mid", {7'd0, sl_arb_request}, 8'h01);
    exp_q = '{8'h56, 8'hB2, 8'h03, 8'h01, 8'h00, 8'h00};
    read_frame("overlap_f2");
    #1 check("overlap_req_after", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    // Reset in the middle of reading discards the buffer
    tx_q = '{8'hC1, 8'h04, 8'h00, 8'h00};
    send_frame(8'h56, 1'b0);
    sl_arb_grant = 1'b1; sl_data_latch = 1'b1;
    repeat (2) @(negedge clk);
    sl_arb_grant = 1'b0; sl_data_latch = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", {7'd0, sl_arb_request}, 8'h00);
    check("midrst_drop", drop_count, 8'h00);
    tx_q = '{8'hC2, 8'h04, 8'h00, 8'h00};
    send_frame(8'h56, 1'b0);
    exp_q = '{8'h56, 8'hC2, 8'h01, 8'h00};
    read_frame("midrst");
    #1 check("midrst_req_after", {7'd0, sl_arb_request}, 8'h00);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
